// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern pixel source.
// Holds the 8/8/8 RGB pixel type, the named colour constants used by every
// pattern, the pattern-select encodings and the colour-bar lookup.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t WHITE   = 24'hFF_FF_FF;
  localparam rgb_t YELLOW  = 24'hFF_FF_00;
  localparam rgb_t CYAN    = 24'h00_FF_FF;
  localparam rgb_t GREEN   = 24'h00_FF_00;
  localparam rgb_t MAGENTA = 24'hFF_00_FF;
  localparam rgb_t RED     = 24'hFF_00_00;
  localparam rgb_t BLUE    = 24'h00_00_FF;
  localparam rgb_t BLACK   = 24'h00_00_00;
  localparam rgb_t NAVY    = 24'h00_00_80;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  // Classic eight-bar order, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream interface between the timing generator, the pattern source
// and whatever consumes the coloured stream.
//   hsync_in/vsync_in/de_in, hdata/vdata : raw timing and pixel coordinates
//   mode                                 : pattern select
//   r/g/b, hsync/vsync/de                : coloured pixel with aligned sync
// master = the side that drives timing and watches pixels (source/bench),
// slave  = the pattern generator.
interface vga_pattern_gen_if #(
  parameter int W = 12
);
  logic         hsync_in;
  logic         vsync_in;
  logic         de_in;
  logic [W-1:0] hdata;
  logic [W-1:0] vdata;
  logic [1:0]   mode;
  logic [7:0]   r;
  logic [7:0]   g;
  logic [7:0]   b;
  logic         hsync;
  logic         vsync;
  logic         de;

  modport master (
    output hsync_in, vsync_in, de_in, hdata, vdata, mode,
    input  r, g, b, hsync, vsync, de
  );

  modport slave (
    input  hsync_in, vsync_in, de_in, hdata, vdata, mode,
    output r, g, b, hsync, vsync, de
  );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position keeper.
// Moves the box by STEP pixels per axis on every frame_start pulse and
// bounces it off the active-area edges, clamping so the box never leaves
// the visible region.
//   clk, rst     : pixel clock, synchronous active-high reset
//   frame_start  : one-cycle pulse at the start of each frame
//   box_x, box_y : top-left corner of the box
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int W        = 12,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int BOX      = 64,
  parameter int STEP     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  output logic [W-1:0] box_x,
  output logic [W-1:0] box_y
);

  localparam logic [W:0] STEP_W = (W+1)'(STEP);
  localparam logic [W:0] BOX_W  = (W+1)'(BOX);
  localparam logic [W:0] H_LIM  = (W+1)'(H_ACTIVE);
  localparam logic [W:0] V_LIM  = (W+1)'(V_ACTIVE);

  // dir = 1 means moving towards larger coordinates.
  typedef struct packed {
    logic [W-1:0] pos;
    logic         dir;
  } axis_t;

  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic         dx_q, dx_d, dy_q, dy_d;
  axis_t        x_nxt, y_nxt;

  // One extra bit of headroom so pos+STEP+BOX cannot wrap before the compare.
  function automatic axis_t bounce(input logic [W-1:0] pos, input logic dir,
                                   input logic [W:0] limit);
    logic [W:0] pos_w;
    axis_t      nxt;
    pos_w = {1'b0, pos};
    if (dir) begin
      if (pos_w + STEP_W + BOX_W > limit) begin
        nxt.pos = W'(limit - BOX_W);
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = W'(pos_w + STEP_W);
        nxt.dir = 1'b1;
      end
    end else begin
      if (pos_w < STEP_W) begin
        nxt.pos = '0;
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = W'(pos_w - STEP_W);
        nxt.dir = 1'b0;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    x_nxt = bounce(x_q, dx_q, H_LIM);
    y_nxt = bounce(y_q, dy_q, V_LIM);
    x_d   = x_q;
    dx_d  = dx_q;
    y_d   = y_q;
    dy_d  = dy_q;
    if (frame_start) begin
      x_d  = x_nxt.pos;
      dx_d = x_nxt.dir;
      y_d  = y_nxt.pos;
      dy_d = y_nxt.dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign box_x = x_q;
  assign box_y = y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source sitting right after the VGA timing generator.
// Turns raw timing (sync, de, x/y) into a 24-bit RGB test pattern with
// sync/de delayed so they stay aligned with the colour. Fixed 2-cycle
// latency in every mode; the pattern select is only taken at frame start.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : slave side of vga_pattern_gen_if (timing in, pixel out, mode)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int W        = 12,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int BOX      = 64,
  parameter int STEP     = 4
) (
  input logic                clk,
  input logic                rst,
  vga_pattern_gen_if.slave   bus
);

  localparam int         BAR_W = H_ACTIVE / 8;
  localparam logic [W:0] BOX_W = (W+1)'(BOX);
  localparam logic [W:0] H_LIM = (W+1)'(H_ACTIVE);

  // Stage 1: delayed sync/de plus per-pattern region flags.
  logic       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic       bar_oob_q, bar_oob_d;
  logic       checker_q, checker_d;
  logic       grid_q, grid_d;
  logic       in_box_q, in_box_d;

  // Stage 2: output registers.
  logic       hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  rgb_t       rgb2_q, rgb2_d;

  mode_e      mode_q, mode_d;
  logic       frame_start;

  logic [W-1:0] box_x, box_y;
  logic [W:0]   hx, vy, bx, by;

  // The registered vsync copy doubles as the edge-detect reference.
  assign frame_start = (bus.vsync_in == VS_POL) && (vs1_q != VS_POL);

  vga_box_mover #(
    .W        (W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX      (BOX),
    .STEP     (STEP)
  ) u_box_mover (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .box_x       (box_x),
    .box_y       (box_y)
  );

  // Stage 1 reduces the coordinates to the few flags each pattern needs, so
  // the raw coordinates never have to travel into stage 2.
  always_comb begin
    hs1_d  = bus.hsync_in;
    vs1_d  = bus.vsync_in;
    de1_d  = bus.de_in;
    mode_d = frame_start ? mode_e'(bus.mode) : mode_q;

    // Bar index counts thresholds crossed; a compare chain avoids a divider.
    bar_idx_d = '0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, bus.hdata} >= (W+1)'(k * BAR_W)) begin
        bar_idx_d = bar_idx_d + 3'd1;
      end
    end
    bar_oob_d = ({1'b0, bus.hdata} >= H_LIM);

    checker_d = bus.hdata[5] ^ bus.vdata[5];

    grid_d = (bus.hdata[5:0] == 6'd0) || (bus.vdata[5:0] == 6'd0) ||
             (bus.hdata == W'(H_ACTIVE - 1)) || (bus.vdata == W'(V_ACTIVE - 1));

    hx = {1'b0, bus.hdata};
    vy = {1'b0, bus.vdata};
    bx = {1'b0, box_x};
    by = {1'b0, box_y};
    in_box_d = (hx >= bx) && (hx < bx + BOX_W) &&
               (vy >= by) && (vy < by + BOX_W);
  end

  // Stage 2 picks the colour for the latched mode and blanks outside de.
  always_comb begin
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    case (mode_q)
      MODE_BARS:    rgb2_d = bar_oob_q ? BLACK : bar_colour(bar_idx_q);
      MODE_CHECKER: rgb2_d = checker_q ? WHITE : BLACK;
      MODE_GRID:    rgb2_d = grid_q ? WHITE : BLACK;
      MODE_BOX:     rgb2_d = in_box_q ? RED : NAVY;
      default:      rgb2_d = BLACK;
    endcase
    if (!de1_q) begin
      rgb2_d = BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs1_q     <= ~HS_POL;
      vs1_q     <= ~VS_POL;
      de1_q     <= 1'b0;
      bar_idx_q <= '0;
      bar_oob_q <= 1'b0;
      checker_q <= 1'b0;
      grid_q    <= 1'b0;
      in_box_q  <= 1'b0;
      hs2_q     <= ~HS_POL;
      vs2_q     <= ~VS_POL;
      de2_q     <= 1'b0;
      rgb2_q    <= BLACK;
      mode_q    <= MODE_BARS;
    end else begin
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      de1_q     <= de1_d;
      bar_idx_q <= bar_idx_d;
      bar_oob_q <= bar_oob_d;
      checker_q <= checker_d;
      grid_q    <= grid_d;
      in_box_q  <= in_box_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      de2_q     <= de2_d;
      rgb2_q    <= rgb2_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.r     = rgb2_q.r;
  assign bus.g     = rgb2_q.g;
  assign bus.b     = rgb2_q.b;
  assign bus.hsync = hs2_q;
  assign bus.vsync = vs2_q;
  assign bus.de    = de2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset state, 2-cycle alignment,
// every pattern at its edges, frame-boundary mode switching, box bounce
// and reset in the middle of a line.
module tb_vga_pattern_gen;

  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW = 24'hFFFF00;
  localparam logic [23:0] C_CYAN   = 24'h00FFFF;
  localparam logic [23:0] C_GREEN  = 24'h00FF00;
  localparam logic [23:0] C_MAG    = 24'hFF00FF;
  localparam logic [23:0] C_RED    = 24'hFF0000;
  localparam logic [23:0] C_BLUE   = 24'h0000FF;
  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_NAVY   = 24'h000080;
  // {de, hsync, vsync, rgb} with both syncs idle high
  localparam logic [26:0] IDLE_OUT = {3'b011, 24'h000000};

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   frames = 0;

  vga_pattern_gen_if #(.W(12)) bus ();

  vga_pattern_gen #(
    .W(12), .H_ACTIVE(1920), .V_ACTIVE(1080),
    .HS_POL(1'b0), .VS_POL(1'b0), .BOX(64), .STEP(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic hs, input logic vs, input logic d,
                               input int h, input int v);
    @(negedge clk);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.de_in    = d;
    bus.hdata    = 12'(h);
    bus.vdata    = 12'(v);
  endtask

  task automatic checkOutput(input string tag, input logic [26:0] exp);
    logic [26:0] obs;
    obs = {bus.de, bus.hsync, bus.vsync, bus.r, bus.g, bus.b};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel in, idle after it, check the output two cycles later.
  task automatic send_pixel(input string tag, input int h, input int v,
                            input logic d, input logic [23:0] rgb);
    applyStimulus(1'b1, 1'b1, d, h, v);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput(tag, {d, 1'b1, 1'b1, rgb});
  endtask

  task automatic new_frame();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic advance_to(input int n);
    while (frames < n) begin
      new_frame();
      frames++;
    end
  endtask

  task automatic check_box(input int x, input int y);
    send_pixel($sformatf("box_in_f%0d", frames), x, y, 1'b1, C_RED);
    send_pixel($sformatf("box_left_f%0d", frames), x - 1, y, 1'b1, C_NAVY);
    send_pixel($sformatf("box_right_f%0d", frames), x + 64, y, 1'b1, C_NAVY);
    send_pixel($sformatf("box_corner_f%0d", frames), x + 63, y + 63, 1'b1, C_RED);
    send_pixel($sformatf("box_above_f%0d", frames), x, y - 1, 1'b1, C_NAVY);
  endtask

  initial begin
    rst          = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.de_in    = 1'b0;
    bus.hdata    = '0;
    bus.vdata    = '0;
    bus.mode     = 2'd0;

    // Reset state, then still idle after release.
    repeat (2) @(negedge clk);
    checkOutput("reset_state", IDLE_OUT);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_release", IDLE_OUT);

    // Combined hsync/de pulse must surface exactly two cycles later.
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("pulse_lat1", IDLE_OUT);
    @(negedge clk);
    checkOutput("pulse_lat2", {3'b101, C_WHITE});
    @(negedge clk);
    checkOutput("pulse_lat3", IDLE_OUT);

    // Colour bars.
    send_pixel("bar_0", 0, 10, 1'b1, C_WHITE);
    send_pixel("bar_239", 239, 10, 1'b1, C_WHITE);
    send_pixel("bar_240", 240, 10, 1'b1, C_YELLOW);
    send_pixel("bar_480", 480, 10, 1'b1, C_CYAN);
    send_pixel("bar_720", 720, 10, 1'b1, C_GREEN);
    send_pixel("bar_960", 960, 10, 1'b1, C_MAG);
    send_pixel("bar_1200", 1200, 10, 1'b1, C_RED);
    send_pixel("bar_1679", 1679, 10, 1'b1, C_BLUE);
    send_pixel("bar_1680", 1680, 10, 1'b1, C_BLACK);
    send_pixel("bar_1919", 1919, 10, 1'b1, C_BLACK);
    send_pixel("bar_blank", 100, 10, 1'b0, C_BLACK);

    // Checkerboard.
    bus.mode = 2'd1;
    new_frame();
    send_pixel("chk_31_0", 31, 0, 1'b1, C_BLACK);
    send_pixel("chk_32_0", 32, 0, 1'b1, C_WHITE);
    send_pixel("chk_32_32", 32, 32, 1'b1, C_BLACK);

    // Grid.
    bus.mode = 2'd2;
    new_frame();
    send_pixel("grid_64_5", 64, 5, 1'b1, C_WHITE);
    send_pixel("grid_65_5", 65, 5, 1'b1, C_BLACK);
    send_pixel("grid_1919_500", 1919, 500, 1'b1, C_WHITE);
    send_pixel("grid_100_1079", 100, 1079, 1'b1, C_WHITE);

    // Mid-frame mode change waits for the next frame start.
    bus.mode = 2'd0;
    new_frame();
    send_pixel("switch_before", 240, 500, 1'b1, C_YELLOW);
    bus.mode = 2'd1;
    send_pixel("switch_midframe", 240, 500, 1'b1, C_YELLOW);
    new_frame();
    send_pixel("switch_after", 240, 500, 1'b1, C_BLACK);
    send_pixel("switch_after_v0", 240, 0, 1'b1, C_WHITE);

    // Fresh start for the box: reset puts it at (0,0) moving +.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mode = 2'd3;
    frames = 0;
    advance_to(1);
    check_box(4, 4);
    advance_to(25);
    check_box(100, 100);

    // Reset in the middle of a line with the box at (100,100).
    applyStimulus(1'b1, 1'b1, 1'b1, 100, 100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midline_before", {3'b111, C_RED});
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midline_reset", IDLE_OUT);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midline_rel1", IDLE_OUT);
    @(negedge clk);
    checkOutput("midline_rel2", {3'b111, C_WHITE});
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    frames = 0;
    advance_to(1);
    send_pixel("restart_box", 4, 4, 1'b1, C_RED);
    send_pixel("restart_old", 100, 100, 1'b1, C_NAVY);

    // Long bounce run: y clamps at 1016 on frame 254, x at 1856 on 464.
    advance_to(254);
    check_box(1016, 1016);
    advance_to(255);
    check_box(1020, 1016);
    advance_to(256);
    check_box(1024, 1012);
    advance_to(463);
    check_box(1852, 184);
    advance_to(464);
    check_box(1856, 180);
    advance_to(465);
    check_box(1856, 176);
    advance_to(466);
    check_box(1852, 172);
    advance_to(480);
    check_box(1796, 116);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
